// File: rtl/madd_sweep_err_checker.sv
// Exhaustive sweep harness for an approximate 6-in/4-out multiply-add circuit.
// Steps stim through all 64 vectors and accumulates error statistics against a*b+c.
module madd_sweep_err_checker #(
    parameter int ET    = 6,
    parameter int SUM_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [5:0]       stim,
    input  logic [3:0]       approx,
    output logic             busy,
    output logic             done,
    output logic [3:0]       max_err,
    output logic [6:0]       mism_cnt,
    output logic [6:0]       viol_cnt,
    output logic [SUM_W-1:0] sum_err,
    output logic             pass
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t     state;
    logic [5:0] idx;
    logic [3:0] exact;
    logic [3:0] err;

    // Exact reference for the vector currently on stim; the circuit is combinational.
    always_comb begin
        exact = 4'({2'b00, idx[1:0]} * {2'b00, idx[3:2]}) + {2'b00, idx[5:4]};
        err   = (approx >= exact) ? (approx - exact) : (exact - approx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            max_err  <= '0;
            mism_cnt <= '0;
            viol_cnt <= '0;
            sum_err  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= RUN;
                        idx      <= '0;
                        max_err  <= '0;
                        mism_cnt <= '0;
                        viol_cnt <= '0;
                        sum_err  <= '0;
                    end
                end
                RUN: begin
                    sum_err  <= sum_err + SUM_W'(err);
                    if (err > max_err)
                        max_err <= err;
                    if (err != 4'd0)
                        mism_cnt <= mism_cnt + 7'd1;
                    if (32'(err) > ET)
                        viol_cnt <= viol_cnt + 7'd1;
                    // idx stays at 63 in DONE so stim holds the last vector.
                    if (idx == 6'd63)
                        state <= DONE;
                    else
                        idx <= idx + 6'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign stim = idx;
    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign pass = (state == DONE) && (viol_cnt == 7'd0);

endmodule

// File: tb/tb_madd_sweep_err_checker.sv
// Table-driven bench for madd_sweep_err_checker: several approx models, ET=6 and ET=7 instances.
module tb_madd_sweep_err_checker;

    logic       clock = 1'b0;
    logic       reset;
    logic       startA, startB;
    logic [5:0] stimA, stimB;
    logic [3:0] approxA, approxB;
    logic       busyA, busyB, doneA, doneB, passA, passB;
    logic [3:0] maxErrA, maxErrB;
    logic [6:0] mismCntA, mismCntB, violCntA, violCntB;
    logic [9:0] sumErrA, sumErrB;

    int mode;
    int assertCount = 0;
    int failCount = 0;

    typedef struct {
        int mode;
        int etSel;
        int expMax;
        int expMism;
        int expViol;
        int expSum;
        int expPass;
    } vector_t;

    vector_t vectors[5];

    always #5 clock = ~clock;

    madd_sweep_err_checker #(.ET(6), .SUM_W(10)) dutA (
        .clk(clock), .rst(reset), .start(startA), .stim(stimA), .approx(approxA),
        .busy(busyA), .done(doneA), .max_err(maxErrA), .mism_cnt(mismCntA),
        .viol_cnt(violCntA), .sum_err(sumErrA), .pass(passA)
    );

    madd_sweep_err_checker #(.ET(7), .SUM_W(10)) dutB (
        .clk(clock), .rst(reset), .start(startB), .stim(stimB), .approx(approxB),
        .busy(busyB), .done(doneB), .max_err(maxErrB), .mism_cnt(mismCntB),
        .viol_cnt(violCntB), .sum_err(sumErrB), .pass(passB)
    );

    function automatic logic [3:0] model(input logic [5:0] s, input int m);
        int a, b, c, e;
        a = int'(s[1:0]);
        b = int'(s[3:2]);
        c = int'(s[5:4]);
        e = a * b + c;
        case (m)
            1:       return 4'd0;
            2:       return 4'd15;
            3:       return (s == 6'd37) ? 4'(e + 7) : 4'(e);
            default: return 4'(e);
        endcase
    endfunction

    // Approximate-circuit stand-ins, combinational from each DUT's stimulus.
    always_comb begin
        approxA = model(stimA, mode);
        approxB = model(stimB, mode);
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkStats(input int sel, input string tag, input int expMax, input int expMism,
                              input int expViol, input int expSum, input int expPass);
        checkOutput({tag, " done"},     sel ? int'(doneB) : int'(doneA), 1);
        checkOutput({tag, " busy"},     sel ? int'(busyB) : int'(busyA), 0);
        checkOutput({tag, " stim"},     sel ? int'(stimB) : int'(stimA), 63);
        checkOutput({tag, " max_err"},  sel ? int'(maxErrB) : int'(maxErrA), expMax);
        checkOutput({tag, " mism_cnt"}, sel ? int'(mismCntB) : int'(mismCntA), expMism);
        checkOutput({tag, " viol_cnt"}, sel ? int'(violCntB) : int'(violCntA), expViol);
        checkOutput({tag, " sum_err"},  sel ? int'(sumErrB) : int'(sumErrA), expSum);
        checkOutput({tag, " pass"},     sel ? int'(passB) : int'(passA), expPass);
    endtask

    // Pulses start on the chosen DUT and counts busy cycles until it drops (bounded).
    task automatic applyStimulus(input int sel, input int pokeAt, output int cycles);
        if (sel) startB = 1'b1; else startA = 1'b1;
        tick();
        startA = 1'b0;
        startB = 1'b0;
        cycles = 0;
        while ((sel ? busyB : busyA) && cycles < 200) begin
            if (cycles == pokeAt) begin
                if (sel) startB = 1'b1; else startA = 1'b1;
            end else begin
                startA = 1'b0;
                startB = 1'b0;
            end
            tick();
            cycles++;
        end
        startA = 1'b0;
        startB = 1'b0;
    endtask

    task automatic checkIdleZero(input string tag);
        checkOutput({tag, " stim"},     int'(stimA), 0);
        checkOutput({tag, " busy"},     int'(busyA), 0);
        checkOutput({tag, " done"},     int'(doneA), 0);
        checkOutput({tag, " pass"},     int'(passA), 0);
        checkOutput({tag, " max_err"},  int'(maxErrA), 0);
        checkOutput({tag, " mism_cnt"}, int'(mismCntA), 0);
        checkOutput({tag, " viol_cnt"}, int'(violCntA), 0);
        checkOutput({tag, " sum_err"},  int'(sumErrA), 0);
    endtask

    initial begin
        int cycles;
        vectors[0] = '{0, 0, 0, 0, 0, 0, 1};
        vectors[1] = '{1, 0, 12, 57, 11, 240, 0};
        vectors[2] = '{2, 0, 15, 64, 58, 720, 0};
        vectors[3] = '{3, 0, 7, 1, 1, 7, 0};
        vectors[4] = '{3, 1, 7, 1, 0, 7, 1};

        mode   = 0;
        startA = 1'b0;
        startB = 1'b0;
        reset  = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checkIdleZero("reset");

        for (int i = 0; i < 5; i++) begin
            mode = vectors[i].mode;
            applyStimulus(vectors[i].etSel, -1, cycles);
            checkOutput($sformatf("vec%0d run cycles", i), cycles, 64);
            checkStats(vectors[i].etSel, $sformatf("vec%0d", i), vectors[i].expMax,
                       vectors[i].expMism, vectors[i].expViol, vectors[i].expSum,
                       vectors[i].expPass);
        end

        // Reset in the middle of a sweep, then a fresh full sweep.
        mode = 1;
        startA = 1'b1;
        tick();
        startA = 1'b0;
        repeat (30) tick();
        checkOutput("mid busy", int'(busyA), 1);
        checkOutput("mid pass", int'(passA), 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkIdleZero("midreset");
        applyStimulus(0, -1, cycles);
        checkOutput("after reset cycles", cycles, 64);
        checkStats(0, "after reset", 12, 57, 11, 240, 0);

        // start pulsed during RUN must not disturb count or timing.
        mode = 2;
        applyStimulus(0, 20, cycles);
        checkOutput("poke cycles", cycles, 64);
        checkStats(0, "poke", 15, 64, 58, 720, 0);

        // start held high: two back-to-back sweeps with a single done cycle.
        mode = 1;
        startA = 1'b1;
        tick();
        cycles = 0;
        while (busyA && cycles < 200) begin
            tick();
            cycles++;
        end
        checkOutput("b2b first cycles", cycles, 64);
        checkStats(0, "b2b first", 12, 57, 11, 240, 0);
        tick();
        checkOutput("b2b restart busy", int'(busyA), 1);
        checkOutput("b2b restart done", int'(doneA), 0);
        checkOutput("b2b cleared sum", int'(sumErrA), 0);
        checkOutput("b2b cleared mism", int'(mismCntA), 0);
        checkOutput("b2b restart stim", int'(stimA), 0);
        cycles = 0;
        while (busyA && cycles < 200) begin
            tick();
            cycles++;
        end
        startA = 1'b0;
        checkOutput("b2b second cycles", cycles, 64);
        checkStats(0, "b2b second", 12, 57, 11, 240, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
